// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard-detection inputs from the pipeline and the stage enable/flush controls back to it.
// HAZARD_PERF_EN adds the stall and flush performance counters.
interface hazard_ctrl_if;
    logic [4:0] iIDRs;
    logic [4:0] iIDRt;
    logic iIDUsesRt;
    logic iEXMemRead;
    logic [4:0] iEXRegDest;
    logic iEXRedirect;
    logic iMemReq;
    logic iMemReady;
    logic oPCEnable;
    logic oPCSelRedirect;
    logic oIFIDEnable;
    logic oIFIDFlush;
    logic oIDEXEnable;
    logic oIDEXBubble;
    logic oEXMEMEnable;
    logic oMemTimeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] oStallCycles;
    logic [31:0] oFlushCount;
`endif
    modport master (
        output iIDRs, iIDRt, iIDUsesRt, iEXMemRead, iEXRegDest, iEXRedirect, iMemReq, iMemReady,
        input oPCEnable, oPCSelRedirect, oIFIDEnable, oIFIDFlush, oIDEXEnable, oIDEXBubble,
        input oEXMEMEnable, oMemTimeout
`ifdef HAZARD_PERF_EN
        , input oStallCycles, oFlushCount
`endif
    );
    modport slave (
        input iIDRs, iIDRt, iIDUsesRt, iEXMemRead, iEXRegDest, iEXRedirect, iMemReq, iMemReady,
        output oPCEnable, oPCSelRedirect, oIFIDEnable, oIFIDFlush, oIDEXEnable, oIDEXBubble,
        output oEXMEMEnable, oMemTimeout
`ifdef HAZARD_PERF_EN
        , output oStallCycles, oFlushCount
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline stall/flush controller with data-memory watchdog.
// Define HAZARD_PERF_EN to add the stall-cycle and flush counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input logic clock,
    input logic resetn,
    hazard_ctrl_if.slave bus
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {RUN, FREEZE, ERROR} state_t;

    state_t state;
    logic [CW-1:0] waitCount;
    logic [CW-1:0] waitNext;
    logic memWait;
    logic loadUse;
    logic active;
    logic go;
    logic timeoutHit;

    always_comb begin
        memWait = bus.iMemReq & ~bus.iMemReady;
        loadUse = bus.iEXMemRead & (bus.iEXRegDest != 5'd0) &
                  ((bus.iEXRegDest == bus.iIDRs) | (bus.iIDUsesRt & (bus.iEXRegDest == bus.iIDRt)));
        active = resetn & (state != ERROR);
        go = active & ~memWait;
        // redirect outranks load-use: the ID instruction is on the wrong path
        bus.oPCEnable = go & (bus.iEXRedirect | ~loadUse);
        bus.oIFIDEnable = go & (bus.iEXRedirect | ~loadUse);
        bus.oIDEXEnable = go;
        bus.oEXMEMEnable = go;
        bus.oPCSelRedirect = go & bus.iEXRedirect;
        bus.oIFIDFlush = go & bus.iEXRedirect;
        bus.oIDEXBubble = go & (bus.iEXRedirect | loadUse);
        bus.oMemTimeout = resetn & (state == ERROR);
        waitNext = (&waitCount) ? waitCount : waitCount + 1'b1;
        timeoutHit = (MEM_TIMEOUT != 0) && (waitNext == CW'(MEM_TIMEOUT));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            waitCount <= '0;
        end else begin
            case (state)
                RUN: begin
                    waitCount <= '0;
                    if (memWait) state <= FREEZE;
                end
                FREEZE: begin
                    if (bus.iMemReady) begin
                        state <= RUN;
                        waitCount <= '0;
                    end else if (memWait) begin
                        waitCount <= waitNext;
                        if (timeoutHit) state <= ERROR;
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.oStallCycles <= '0;
            bus.oFlushCount <= '0;
        end else begin
            if (state != ERROR && !bus.oPCEnable) bus.oStallCycles <= bus.oStallCycles + 32'd1;
            if (bus.oPCSelRedirect) bus.oFlushCount <= bus.oFlushCount + 32'd1;
        end
    end
`endif
endmodule
